piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
Parallel-in serial-out transmitter, the sending end of the 16-bit serial link whose receiver is our SIPO shifter. Accepts words over a valid/ready handshake and shifts each one out MSB first, one bit per bit period. A one-word holding buffer allows gapless back-to-back frames. The output feeds the SIPO serial input directly, with the same clock, or feeds an off-block serial line.

Parameters:
WIDTH, 16, word width in bits; must be >= 2.
CLKS_PER_BIT, 1, clk cycles each bit is held on serial_out; must be >= 1.
IDLE_LEVEL, 1'b0, serial_out level when no frame is active.

Ports:
clk  in  1  system clock, 100 MHz, all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
data_in  in  WIDTH  word to transmit
data_valid  in  1  data_in valid; must not depend on data_ready
data_ready  out  1  block can accept a word this cycle
serial_out  out  1  serial data, MSB first
frame_out  out  1  high while a word bit is being driven
word_done  out  1  one-cycle pulse after a word's last bit period ends

Behaviour:
- Reset (rst==0 at a posedge): state IDLE; serial_out=IDLE_LEVEL; frame_out=0; word_done=0; hold buffer empty; bit and divider counters 0.
- data_ready is combinational: data_ready = rst & ~hold_full. It is 0 while rst is low and 1 in the first cycle after reset release.
- Transfer: a word transfers when data_valid & data_ready are both high at a posedge.
  - If the shifter is IDLE, or is in the final cycle of its current word, the word goes straight to the shifter.
  - Otherwise the word goes to the hold buffer.
- States:
  - IDLE: frame_out=0, serial_out=IDLE_LEVEL. On a transfer, load the shifter and go to SHIFT.
  - SHIFT: serial_out = shifter MSB, frame_out=1. bit_cnt counts WIDTH-1 down to 0; div_cnt counts 0 to CLKS_PER_BIT-1. When div_cnt wraps, the shifter shifts left and bit_cnt decrements.
- Latency: a word accepted at edge N drives its MSB on serial_out from edge N in IDLE. A frame lasts exactly WIDTH*CLKS_PER_BIT cycles.
- Final cycle of a word is bit_cnt==0 && div_cnt==CLKS_PER_BIT-1. At the closing edge:
  - If hold_full: load from hold, clear hold, stay in SHIFT. frame_out stays high with no gap.
  - Else, if a transfer occurs: load the new word directly and stay in SHIFT.
  - Else: go to IDLE. serial_out returns to IDLE_LEVEL and frame_out drops.
- word_done is registered and is high for the one cycle following each word's final cycle, for every completed word.
- Simultaneous events: a transfer while hold_full cannot occur, because data_ready is low. A hold-to-shifter move and a new transfer in the same edge place the new word in hold.
- Reset mid-word: the frame is aborted immediately, the hold content is discarded, and no word_done is issued.
- Changes on data_in while data_ready=0 or data_valid=0 have no effect.
- SIPO compatibility: serial_out changes only on rising edges. It is therefore stable at the SIPO's sampling (falling) edge. With CLKS_PER_BIT=1, WIDTH=16, the SIPO holds the transmitted word after the 16 frame cycles.

Decomposition:
- Shared package serial_link_pkg holds:
  - WORD_WIDTH=16 localparam;
  - IDLE/SHIFT state encodings;
  - the IDLE_LEVEL default.
- One sub-module, bit_timer, contains div_cnt. It takes clk, rst and enable, and outputs a bit_end tick; it is parameterised by CLKS_PER_BIT.
- Shifter, hold buffer and FSM stay in piso_tx.

Test Plan:
1. Reset behaviour: rst=0 for 3 cycles with data_valid=1 -> serial_out=0, frame_out=0, word_done=0, data_ready=0. After release, data_ready=1 on the next cycle.
2. Single word: data_in=16'hA5C3, CLKS_PER_BIT=1 -> serial_out gives 1010_0101_1100_0011 on 16 consecutive cycles; frame_out high for 16 cycles; word_done pulses once. A looped-back SIPO shows bus_out=16'hA5C3.
3. Back-to-back: 16'hFFFF, 16'h0001 and 16'h8000 with data_valid held -> 48 contiguous frame_out cycles with no gap; data_ready drops while hold is full; 3 word_done pulses.
4. Slow rate: CLKS_PER_BIT=4, word 16'h8001 -> MSB 1 for 4 cycles, then 0 for 56 cycles, then 1 for 4 cycles; frame lasts 64 cycles.
5. Reset mid-word: rst=0 during bit 7 of 16'hFF00 with a word in hold -> serial_out=IDLE_LEVEL and frame_out=0 the next cycle, no word_done. The next word 16'h1234 then transmits cleanly.
6. Backpressure: data_valid high while data_ready=0, with data_in toggling -> only the value present at the handshake edge is transmitted.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the 16-bit serial link (PISO transmitter / SIPO receiver).
//   WORD_WIDTH         : native word width of the link
//   tx_state_t         : transmitter FSM states (IDLE / SHIFT)
//   IDLE_LEVEL_DEFAULT : serial line level when no frame is active
package serial_link_pkg;

  localparam int unsigned WORD_WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider for the serial transmitter.
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active low
//   enable  : count while high; counter held at 0 while low
//   bit_end : high in the last clk cycle of each bit period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign bit_end = enable && (div_cnt_q == DIV_MAX);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!enable || bit_end) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with a one-word hold buffer
// for gapless back-to-back frames.
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active low
//   data_in    : word to transmit
//   data_valid : data_in valid (independent of data_ready)
//   data_ready : word can be accepted this cycle (combinational)
//   serial_out : serial data, MSB first
//   frame_out  : high while a word bit is driven
//   word_done  : one-cycle pulse after a word's last bit period
module piso_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH        = WORD_WIDTH,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter logic        IDLE_LEVEL   = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame_out,
  output logic             word_done
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] BIT_MAX = BCW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             word_done_q, word_done_d;

  logic bit_end;
  logic xfer;
  logic last;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q == ST_SHIFT),
    .bit_end(bit_end)
  );

  assign data_ready = rst & ~hold_full_q;
  assign xfer       = data_valid & data_ready;
  assign last       = (state_q == ST_SHIFT) && (bit_cnt_q == '0) && bit_end;

  assign serial_out = (state_q == ST_SHIFT) ? shift_q[WIDTH-1] : IDLE_LEVEL;
  assign frame_out  = (state_q == ST_SHIFT);
  assign word_done  = word_done_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    word_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shift_d   = data_in;
          bit_cnt_d = BIT_MAX;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          word_done_d = 1'b1;
          if (hold_full_q) begin
            // Held word takes priority; any concurrent transfer refills hold.
            shift_d     = hold_q;
            bit_cnt_d   = BIT_MAX;
            hold_full_d = 1'b0;
            if (xfer) begin
              hold_d      = data_in;
              hold_full_d = 1'b1;
            end
          end else if (xfer) begin
            shift_d   = data_in;
            bit_cnt_d = BIT_MAX;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (bit_end) begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BCW'(1);
          end
          if (xfer) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one instance at 1 clk/bit, one at 4 clk/bit.
module tb_piso_tx;

  logic        clk;
  logic        rst;
  logic [15:0] data_in1, data_in4;
  logic        data_valid1, data_valid4;
  logic        data_ready1, data_ready4;
  logic        serial_out1, serial_out4;
  logic        frame_out1, frame_out4;
  logic        word_done1, word_done4;

  int n_checks = 0;
  int n_fail   = 0;

  piso_tx #(
    .WIDTH       (16),
    .CLKS_PER_BIT(1),
    .IDLE_LEVEL  (1'b0)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in1),
    .data_valid(data_valid1),
    .data_ready(data_ready1),
    .serial_out(serial_out1),
    .frame_out (frame_out1),
    .word_done (word_done1)
  );

  piso_tx #(
    .WIDTH       (16),
    .CLKS_PER_BIT(4),
    .IDLE_LEVEL  (1'b0)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in4),
    .data_valid(data_valid4),
    .data_ready(data_ready4),
    .serial_out(serial_out4),
    .frame_out (frame_out4),
    .word_done (word_done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial capture at the falling edge, as the SIPO receiver samples.
  logic        cap;
  logic [63:0] acc1, acc4;
  int          fcnt1, fcnt4, dcnt1, dcnt4, starts1, nready1;
  logic        prev_frame1;

  always @(negedge clk) begin
    if (cap) begin
      if (frame_out1) begin
        acc1  = {acc1[62:0], serial_out1};
        fcnt1 = fcnt1 + 1;
      end
      if (frame_out1 && !prev_frame1) starts1 = starts1 + 1;
      if (word_done1) dcnt1 = dcnt1 + 1;
      if (!data_ready1) nready1 = nready1 + 1;
      prev_frame1 = frame_out1;
      if (frame_out4) begin
        acc4  = {acc4[62:0], serial_out4};
        fcnt4 = fcnt4 + 1;
      end
      if (word_done4) dcnt4 = dcnt4 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver phase: shortly after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    acc1 = '0; acc4 = '0;
    fcnt1 = 0; fcnt4 = 0; dcnt1 = 0; dcnt4 = 0;
    starts1 = 0; nready1 = 0; prev_frame1 = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic send1(input logic [15:0] w);
    int unsigned n;
    n = 0;
    data_in1    = w;
    data_valid1 = 1'b1;
    while (!data_ready1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_eq("send1_timeout", 64'(n), 64'd0);
    tick();
  endtask

  task automatic send4(input logic [15:0] w);
    int unsigned n;
    n = 0;
    data_in4    = w;
    data_valid4 = 1'b1;
    while (!data_ready4 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_eq("send4_timeout", 64'(n), 64'd0);
    tick();
  endtask

  initial begin
    int unsigned n;
    cap = 1'b0;
    clr();
    rst = 1'b0;
    data_in1 = 16'hDEAD; data_valid1 = 1'b1;
    data_in4 = 16'hBEEF; data_valid4 = 1'b1;

    // 1. Reset with valid asserted
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check_eq("rst_serial", 64'(serial_out1), 64'd0);
      check_eq("rst_frame",  64'(frame_out1),  64'd0);
      check_eq("rst_done",   64'(word_done1),  64'd0);
      check_eq("rst_ready",  64'(data_ready1), 64'd0);
    end
    tick();
    rst = 1'b1; data_valid1 = 1'b0; data_valid4 = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 64'(data_ready1), 64'd1);
    check_eq("frame_after_rst", 64'(frame_out1), 64'd0);

    // 2. Single word
    tick();
    clr(); cap = 1'b1;
    send1(16'hA5C3);
    data_valid1 = 1'b0;
    ticks(20);
    cap = 1'b0;
    check_eq("single_bits",   acc1 & 64'hFFFF, 64'hA5C3);
    check_eq("single_frame",  64'(fcnt1), 64'd16);
    check_eq("single_done",   64'(dcnt1), 64'd1);
    check_eq("single_starts", 64'(starts1), 64'd1);

    // 3. Back-to-back with valid held
    clr(); cap = 1'b1;
    send1(16'hFFFF);
    send1(16'h0001);
    send1(16'h8000);
    data_valid1 = 1'b0;
    ticks(60);
    cap = 1'b0;
    check_eq("b2b_bits",   acc1 & 64'h0000_FFFF_FFFF_FFFF, 64'h0000_FFFF_0001_8000);
    check_eq("b2b_frame",  64'(fcnt1), 64'd48);
    check_eq("b2b_starts", 64'(starts1), 64'd1);
    check_eq("b2b_done",   64'(dcnt1), 64'd3);
    check_eq("b2b_nready", 64'(nready1), 64'd30);

    // 4. Slow rate, 4 clk per bit
    clr(); cap = 1'b1;
    send4(16'h8001);
    data_valid4 = 1'b0;
    ticks(75);
    cap = 1'b0;
    check_eq("slow_bits",  acc4, 64'hF000_0000_0000_000F);
    check_eq("slow_frame", 64'(fcnt4), 64'd64);
    check_eq("slow_done",  64'(dcnt4), 64'd1);

    // 5. Reset mid-word with a word in hold
    clr(); cap = 1'b1;
    send1(16'hFF00);
    send1(16'hABCD);
    data_valid1 = 1'b0;
    ticks(6);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_eq("abort_serial", 64'(serial_out1), 64'd0);
    check_eq("abort_frame",  64'(frame_out1),  64'd0);
    check_eq("abort_ready",  64'(data_ready1), 64'd0);
    rst = 1'b1;
    ticks(3);
    check_eq("abort_frames", 64'(fcnt1), 64'd8);
    check_eq("abort_nodone", 64'(dcnt1), 64'd0);
    clr();
    send1(16'h1234);
    data_valid1 = 1'b0;
    ticks(30);
    cap = 1'b0;
    check_eq("post_abort_bits",  acc1 & 64'hFFFF, 64'h1234);
    check_eq("post_abort_frame", 64'(fcnt1), 64'd16);
    check_eq("post_abort_done",  64'(dcnt1), 64'd1);

    // 6. Backpressure with data_in toggling while not ready
    clr(); cap = 1'b1;
    send1(16'h0F0F);
    send1(16'h3C3C);
    n = 0;
    while (!data_ready1 && n < 100) begin
      data_in1 = 16'($urandom);
      tick();
      n++;
    end
    check_eq("bp_ready_timeout", 64'(n < 100), 64'd1);
    data_in1 = 16'h5A5A;
    tick();
    data_valid1 = 1'b0;
    data_in1    = 16'hFFFF;
    ticks(60);
    cap = 1'b0;
    check_eq("bp_bits",   acc1 & 64'h0000_FFFF_FFFF_FFFF, 64'h0000_0F0F_3C3C_5A5A);
    check_eq("bp_frame",  64'(fcnt1), 64'd48);
    check_eq("bp_starts", 64'(starts1), 64'd1);
    check_eq("bp_done",   64'(dcnt1), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
